pll_reset_sequencer: RTL

Sits directly downstream of the ECP5 PLL wrapper. It is clocked by the PLL output clock and consumes the raw PLL lock flag. It synchronises lock, requires lock to be stable for a programmable period, then holds the core reset for a fixed period before releasing it. On any loss of lock it re-asserts the core reset immediately (after synchronisation). It also services soft-reset requests and counts lock-loss events for debug.

---
 rtl/pll_reset_sequencer_pkg.sv | 18 +
 rtl/bit_synchronizer.sv | 28 ++
 rtl/pll_reset_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, lock-loss
// counter width and its saturating increment.
package pll_reset_sequencer_pkg;

  localparam int LOST_CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_WAIT_LOCK = 2'd0;
  localparam state_t ST_STABLE    = 2'd1;
  localparam state_t ST_HOLD      = 2'd2;
  localparam state_t ST_RUN       = 2'd3;

  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop single-bit synchroniser; all stages clear to 0 on async reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the core in reset until PLL lock has been stable, then for a fixed
// hold period; re-asserts reset on lock loss or soft-reset request.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  soft_reset_req,
  output logic                  core_reset,
  output logic                  ready,
  output logic [LOST_CNT_W-1:0] lock_lost_count,
  output logic [1:0]            state_dbg
);

  localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                              LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_WIDTH  = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);

  logic lock_s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LOST_CNT_W-1:0]   lost_q, lost_d;
  logic                    core_reset_q, core_reset_d;
  logic                    ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // Lock loss takes priority over a coincident soft-reset request.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_reset_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
    endcase

    if (state_q != ST_WAIT_LOCK && !lock_s) lost_d = sat_inc(lost_q);

    // Registered from the next state so the outputs line up with state_q.
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      lost_q       <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_q       <= lost_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
    end
  end

  assign core_reset      = core_reset_q;
  assign ready           = ready_q;
  assign lock_lost_count = lost_q;
  assign state_dbg       = state_q;

endmodule
